mux_reg_n: RTL and testbench

//  Parametrised N-channel, DATA_W-bit registered multiplexer for the multicycle datapath.

---
 rtl/mux_reg_n.sv | 102 ++++++++++
 tb/tb_mux_reg_n.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mux_reg_n.sv
// Registered N-channel multiplexer with load/valid handshake and a saturating error counter.
// Optional feature: define MUX_CONST_CH_EN to reserve the all-ones selector code for CONST_VAL.
module mux_reg_n #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned N_CH      = 8,
  parameter int unsigned SEL_W     = 3,
  parameter int unsigned CONST_VAL = 227,
  parameter int unsigned ERR_W     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [SEL_W-1:0]       selector,
  input  logic [N_CH*DATA_W-1:0] data_in,
  input  logic                   err_clr,
  output logic [DATA_W-1:0]      data_out,
  output logic                   valid,
  output logic                   sel_err,
  output logic [ERR_W-1:0]       err_cnt
);

  localparam logic [DATA_W-1:0] CONST_D  = DATA_W'(CONST_VAL);
  localparam logic [SEL_W-1:0]  RSV_CODE = '1;
  localparam logic [SEL_W:0]    N_CH_W   = (SEL_W+1)'(N_CH);
  localparam logic [ERR_W-1:0]  ERR_MAX  = '1;

  if (N_CH > (2 ** SEL_W)) begin : g_bad_n_ch
    $error("mux_reg_n: N_CH exceeds 2**SEL_W");
  end
  if (N_CH < 2) begin : g_bad_n_ch_min
    $error("mux_reg_n: N_CH must be at least 2");
  end

  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              valid_q, valid_d;
  logic              sel_err_q, sel_err_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

  logic [DATA_W-1:0] ch_sel_c;
  logic              in_range_c;
  logic              is_const_c;

  // Channel pick without a variable part-select into the flattened bus.
  always_comb begin
    ch_sel_c = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (selector == SEL_W'(k)) ch_sel_c = data_in[k*DATA_W +: DATA_W];
    end
  end

  assign in_range_c = ({1'b0, selector} < N_CH_W);

`ifdef MUX_CONST_CH_EN
  assign is_const_c = (selector == RSV_CODE);
`else
  assign is_const_c = 1'b0;
`endif

  // The reserved code takes priority over a real channel; an error event beats err_clr.
  always_comb begin
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    sel_err_d  = sel_err_q;
    err_cnt_d  = err_cnt_q;
    if (err_clr) begin
      sel_err_d = 1'b0;
      err_cnt_d = '0;
    end
    if (load) begin
      if (is_const_c) begin
        data_out_d = CONST_D;
        valid_d    = 1'b1;
      end else if (in_range_c) begin
        data_out_d = ch_sel_c;
        valid_d    = 1'b1;
      end else begin
        sel_err_d = 1'b1;
        if (err_cnt_d != ERR_MAX) err_cnt_d = err_cnt_d + ERR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_q <= '0;
      valid_q    <= 1'b0;
      sel_err_q  <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      sel_err_q  <= sel_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign data_out = data_out_q;
  assign valid    = valid_q;
  assign sel_err  = sel_err_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_mux_reg_n.sv
// Bench for mux_reg_n (DATA_W=32, N_CH=7, SEL_W=3, ERR_W=2): vector table, corner sequences, random vs model.
module tb_mux_reg_n;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned N_CH   = 7;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned ERR_W  = 2;
  localparam int unsigned CONSTV = 227;
  localparam int unsigned CNT_MAX = (1 << ERR_W) - 1;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   load = 1'b0;
  logic [SEL_W-1:0]       selector = '0;
  logic [N_CH*DATA_W-1:0] data_in = '0;
  logic                   err_clr = 1'b0;
  logic [DATA_W-1:0]      data_out;
  logic                   valid;
  logic                   sel_err;
  logic [ERR_W-1:0]       err_cnt;

  mux_reg_n #(
    .DATA_W(DATA_W), .N_CH(N_CH), .SEL_W(SEL_W), .CONST_VAL(CONSTV), .ERR_W(ERR_W)
  ) dut (
    .clk(clk), .reset(reset), .load(load), .selector(selector), .data_in(data_in),
    .err_clr(err_clr), .data_out(data_out), .valid(valid), .sel_err(sel_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [31:0] ch [N_CH];

  // Reference state: what the outputs should read after the next edge.
  logic [31:0] m_data = '0;
  int          m_valid = 0;
  int          m_err = 0;
  int          m_cnt = 0;

  typedef struct {
    logic        r;
    logic        l;
    int          sel;
    logic        clr;
    logic [31:0] exp_d;
    int          exp_v;
    int          exp_e;
    int          exp_c;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Spec rules applied to the reference state, using the pre-edge inputs.
  task automatic model_step(input logic r, input logic l, input int sel, input logic clr);
    if (r) begin
      m_data = '0; m_valid = 0; m_err = 0; m_cnt = 0;
    end else begin
      m_valid = 0;
      if (clr) begin m_err = 0; m_cnt = 0; end
      if (l) begin
`ifdef MUX_CONST_CH_EN
        if (sel == (1 << SEL_W) - 1) begin
          m_data = CONSTV; m_valid = 1;
        end else
`endif
        if (sel < N_CH) begin
          m_data = ch[sel]; m_valid = 1;
        end else begin
          m_err = 1;
          if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        end
      end
    end
  endtask

  task automatic cyc(input logic r, input logic l, input int sel, input logic clr);
    reset = r; load = l; selector = SEL_W'(sel); err_clr = clr;
    for (int k = 0; k < N_CH; k++) data_in[k*DATA_W +: DATA_W] = ch[k];
    model_step(r, l, sel, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string name, input logic [31:0] d, input int v, input int e, input int c);
    chk({name, ".data"}, data_out, d);
    chk({name, ".valid"}, 32'(valid), 32'(v));
    chk({name, ".sel_err"}, 32'(sel_err), 32'(e));
    chk({name, ".err_cnt"}, 32'(err_cnt), 32'(c));
  endtask

  initial begin
    int cnt_seq [5];
    for (int k = 0; k < N_CH; k++) ch[k] = 32'h10 + 32'(k);

    vecs[0] = '{1'b1, 1'b1, 3, 1'b0, 32'h0, 0, 0, 0};
    vecs[1] = '{1'b1, 1'b1, 3, 1'b0, 32'h0, 0, 0, 0};
    for (int i = 0; i < 7; i++) vecs[2+i] = '{1'b0, 1'b1, i, 1'b0, 32'h10 + 32'(i), 1, 0, 0};
    vecs[9]  = '{1'b1, 1'b1, 2, 1'b0, 32'h0, 0, 0, 0};
    vecs[10] = '{1'b0, 1'b1, 2, 1'b0, 32'h12, 1, 0, 0};
    vecs[11] = '{1'b0, 1'b0, 5, 1'b0, 32'h12, 0, 0, 0};

    for (int i = 0; i < 12; i++) begin
      cyc(vecs[i].r, vecs[i].l, vecs[i].sel, vecs[i].clr);
      chk_all($sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_v, vecs[i].exp_e, vecs[i].exp_c);
    end

    // Inputs toggling while load=0 must not disturb data_out.
    cyc(1'b0, 1'b1, 3, 1'b0);
    chk_all("hold_load", 32'h13, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < N_CH; k++) ch[k] = $urandom;
      cyc(1'b0, 1'b0, int'($urandom_range(0, 7)), 1'b0);
      chk_all($sformatf("hold%0d", i), 32'h13, 0, 0, 0);
    end
    for (int k = 0; k < N_CH; k++) ch[k] = 32'h10 + 32'(k);

    cyc(1'b0, 1'b1, 7, 1'b0);
`ifdef MUX_CONST_CH_EN
    chk_all("sel7_const", 32'h000000E3, 1, 0, 0);
`else
    chk_all("sel7_invalid", 32'h13, 0, 1, 1);

    // Saturation at 2**ERR_W-1 and error-beats-clear.
    cnt_seq = '{1, 2, 3, 3, 3};
    cyc(1'b1, 1'b0, 0, 1'b0);
    chk_all("sat_reset", 32'h0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 7, 1'b0);
      chk_all($sformatf("sat%0d", i), 32'h0, 0, 1, cnt_seq[i]);
    end
    cyc(1'b0, 1'b1, 7, 1'b1);
    chk_all("clr_with_err", 32'h0, 0, 1, 1);
    cyc(1'b0, 1'b0, 0, 1'b1);
    chk_all("clr_only", 32'h0, 0, 0, 0);
`endif

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) for (int k = 0; k < N_CH; k++) ch[k] = $urandom;
      cyc(($urandom_range(0, 24) == 0), ($urandom_range(0, 2) != 0),
          int'($urandom_range(0, 7)), ($urandom_range(0, 9) == 0));
      chk_all($sformatf("rnd%0d", i), m_data, m_valid, m_err, m_cnt);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
